// File: rtl/ccg_bist_signature_engine.sv
// LFSR-driven BIST harness: issues pseudo-random vectors to a core and compacts responses in a MISR.
// Optional equivalence compare against a second core is enabled by defining CCG_EQUIV_CHECK_EN.
module ccg_bist_signature_engine #(
  parameter int unsigned     N_IN     = 21,
  parameter int unsigned     N_OUT    = 29,
  parameter int unsigned     LAT      = 0,
  parameter int unsigned     CNT_W    = 16,
  parameter logic [N_IN-1:0] TAPS_IN  = 21'h140000,
  parameter logic [N_OUT-1:0] TAPS_OUT = 29'h14000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] num_vec_i,
  input  logic [N_IN-1:0]  seed_i,
  output logic [N_IN-1:0]  vec_o,
  output logic             vec_valid_o,
  input  logic [N_OUT-1:0] resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] vec_cnt_o,
  output logic [N_OUT-1:0] signature_o
`ifdef CCG_EQUIV_CHECK_EN
  ,
  input  logic [N_OUT-1:0] resp_b_i,
  output logic             mismatch_o,
  output logic [CNT_W-1:0] mismatch_idx_o
`endif
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_num_vec;
  logic [CNT_W-1:0]  r_vec_cnt;
  logic [N_IN-1:0]   r_lfsr;
  logic [N_IN-1:0]   r_vec_hold;
  logic [N_OUT-1:0]  r_misr;

  logic w_start, w_abort, w_clr, w_run, w_last, w_rsp_vld, w_dly_pending;

  assign w_start = (r_state == StIdle) && start_i;
  assign w_abort = (r_state != StIdle) && abort_i;
  assign w_clr   = w_start || w_abort;
  assign w_run   = (r_state == StRun);
  assign w_last  = (r_vec_cnt == r_num_vec - CNT_W'(1));

  // Valid delay line aligning each vector with its response LAT cycles later.
  if (LAT == 0) begin : g_nodly
    assign w_rsp_vld     = w_run;
    assign w_dly_pending = 1'b0;
  end else begin : g_dly
    logic [LAT-1:0] r_vld_dly;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_vld_dly <= '0;
      end else if (w_clr) begin
        r_vld_dly <= '0;
      end else begin
        r_vld_dly <= (r_vld_dly << 1) | LAT'(w_run);
      end
    end
    assign w_rsp_vld     = r_vld_dly[LAT-1];
    // Anything left behind the output slot still needs a cycle to drain.
    assign w_dly_pending = |(r_vld_dly << 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (start_i) w_state_nxt = (num_vec_i == '0) ? StDone : StRun;
      end
      StRun: begin
        if (w_last) w_state_nxt = (LAT > 0) ? StDrain : StDone;
      end
      StDrain: begin
        if (!w_dly_pending) w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (w_abort) w_state_nxt = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_vec  <= '0;
      r_vec_cnt  <= '0;
      r_lfsr     <= '0;
      r_vec_hold <= '0;
      r_misr     <= '0;
    end else if (w_start) begin
      r_num_vec <= num_vec_i;
      r_lfsr    <= (seed_i == '0) ? '1 : seed_i;
      r_vec_cnt <= '0;
      r_misr    <= '0;
    end else begin
      if (w_run) begin
        r_lfsr     <= {r_lfsr[N_IN-2:0], ^(r_lfsr & TAPS_IN)};
        r_vec_hold <= r_lfsr;
        if (r_vec_cnt != '1) r_vec_cnt <= r_vec_cnt + CNT_W'(1);
      end
      if (w_rsp_vld) r_misr <= {r_misr[N_OUT-2:0], ^(r_misr & TAPS_OUT)} ^ resp_i;
    end
  end

`ifdef CCG_EQUIV_CHECK_EN
  logic [CNT_W-1:0] r_rsp_idx;
  logic             r_mismatch;
  logic [CNT_W-1:0] r_mismatch_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_idx      <= '0;
      r_mismatch     <= 1'b0;
      r_mismatch_idx <= '0;
    end else if (w_start) begin
      r_rsp_idx      <= '0;
      r_mismatch     <= 1'b0;
      r_mismatch_idx <= '0;
    end else if (w_rsp_vld) begin
      r_rsp_idx <= r_rsp_idx + CNT_W'(1);
      if (!r_mismatch && (resp_i != resp_b_i)) begin
        r_mismatch     <= 1'b1;
        r_mismatch_idx <= r_rsp_idx;
      end
    end
  end

  assign mismatch_o     = r_mismatch;
  assign mismatch_idx_o = r_mismatch_idx;
`endif

  assign vec_o       = w_run ? r_lfsr : r_vec_hold;
  assign vec_valid_o = w_run;
  assign busy_o      = (r_state == StRun) || (r_state == StDrain);
  assign done_o      = (r_state == StDone) && !abort_i;
  assign vec_cnt_o   = r_vec_cnt;
  assign signature_o = r_misr;

endmodule

// File: tb/tb_ccg_bist_signature_engine.sv
// Scoreboard bench: stimulus pushes expected vectors / end-of-run records, monitors pop and compare.
module tb_ccg_bist_signature_engine;

  typedef struct {
    logic [28:0] sig;
    logic [15:0] cnt;
    int          cyc;
  } done_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  // Instance 0: default parameters (LAT=0, CNT_W=16)
  logic        start0 = 1'b0, abort0 = 1'b0;
  logic [15:0] num0 = '0;
  logic [20:0] seed0 = '0, vec0;
  logic        vv0, busy0, done0;
  logic [15:0] cnt0;
  logic [28:0] resp0 = '0, sig0;
  int          start0_cyc = 0;
  logic        equiv_mode = 1'b0;

  // Instance 1: LAT=2, CNT_W=3
  logic        start1 = 1'b0, abort1 = 1'b0;
  logic [2:0]  num1 = '0;
  logic [20:0] seed1 = '0, vec1;
  logic        vv1, busy1, done1;
  logic [2:0]  cnt1;
  logic [28:0] resp1, sig1;
  int          start1_cyc = 0;
  logic        win1 = 1'b0;

  logic [20:0] exp_vec0_q[$];
  done_t       exp_done0_q[$];
  done_t       exp_done1_q[$];

`ifdef CCG_EQUIV_CHECK_EN
  logic [28:0] respb0;
  logic        mm0, mm1;
  logic [15:0] mmidx0;
  logic [2:0]  mmidx1;
  // Second core diverges in bit 0 from vector index 5 onwards (LAT=0: index = cycle - 1).
  assign respb0 = resp0 ^ {28'd0, (equiv_mode && (cyc - start0_cyc) >= 5)};
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Response window for the LAT=2 run: only cycles 3..5 may be folded in.
  always @* begin
    int k;
    k = cyc - start1_cyc + 1;
    if (!win1) resp1 = '0;
    else if (k == 3) resp1 = 29'h1;
    else if (k == 4 || k == 5) resp1 = 29'h0;
    else resp1 = 29'h100;
  end

  ccg_bist_signature_engine dut (
    .clk(clk), .rst_n(rst_n), .start_i(start0), .abort_i(abort0), .num_vec_i(num0),
    .seed_i(seed0), .vec_o(vec0), .vec_valid_o(vv0), .resp_i(resp0), .busy_o(busy0),
    .done_o(done0), .vec_cnt_o(cnt0), .signature_o(sig0)
`ifdef CCG_EQUIV_CHECK_EN
    , .resp_b_i(respb0), .mismatch_o(mm0), .mismatch_idx_o(mmidx0)
`endif
  );

  ccg_bist_signature_engine #(.LAT(2), .CNT_W(3)) dut_lat2 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort1), .num_vec_i(num1),
    .seed_i(seed1), .vec_o(vec1), .vec_valid_o(vv1), .resp_i(resp1), .busy_o(busy1),
    .done_o(done1), .vec_cnt_o(cnt1), .signature_o(sig1)
`ifdef CCG_EQUIV_CHECK_EN
    , .resp_b_i(resp1), .mismatch_o(mm1), .mismatch_idx_o(mmidx1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event with nothing expected (t=%0t)", name, $time);
  endtask

  // Monitor for instance 0
  always @(negedge clk) begin
    if (rst_n) begin
      if (vv0) begin
        if (exp_vec0_q.size() == 0) flag("vec0_unexpected");
        else check("vec0", 64'(vec0), 64'(exp_vec0_q.pop_front()));
      end
      if (done0) begin
        if (exp_done0_q.size() == 0) flag("done0_unexpected");
        else begin
          done_t e;
          e = exp_done0_q.pop_front();
          check("sig0", 64'(sig0), 64'(e.sig));
          check("cnt0", 64'(cnt0), 64'(e.cnt));
          check("done0_cycle", 64'(cyc - start0_cyc + 1), 64'(e.cyc));
          check("busy0_at_done", 64'(busy0), 64'(0));
        end
      end
    end
  end

  // Monitor for instance 1
  always @(negedge clk) begin
    if (rst_n && done1) begin
      if (exp_done1_q.size() == 0) flag("done1_unexpected");
      else begin
        done_t e;
        e = exp_done1_q.pop_front();
        check("sig1", 64'(sig1), 64'(e.sig));
        check("cnt1", 64'(cnt1), 64'(e.cnt));
        check("done1_cycle", 64'(cyc - start1_cyc + 1), 64'(e.cyc));
      end
    end
  end

  task automatic start_run0(input logic [20:0] seed, input logic [15:0] num);
    @(negedge clk);
    seed0  = seed;
    num0   = num;
    start0 = 1'b1;
    @(posedge clk);
    #1 start0_cyc = cyc;
    start0 = 1'b0;
  endtask

  task automatic start_run1(input logic [20:0] seed, input logic [2:0] num);
    @(negedge clk);
    seed1  = seed;
    num1   = num;
    start1 = 1'b1;
    @(posedge clk);
    #1 start1_cyc = cyc;
    start1 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      seen = (which == 0) ? done0 : done1;
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL done%0d_timeout: no done within %0d cycles", which, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_vec", 64'(vec0), 64'(0));
    check("rst_valid", 64'(vv0), 64'(0));
    check("rst_busy", 64'(busy0), 64'(0));
    check("rst_done", 64'(done0), 64'(0));
    check("rst_cnt", 64'(cnt0), 64'(0));
    check("rst_sig", 64'(sig0), 64'(0));

    // Zero-length run: done in cycle 1, no vectors.
    exp_done0_q.push_back(done_t'{sig: 29'h0, cnt: 16'd0, cyc: 1});
    start_run0(21'h1, 16'd0);
    wait_done(0, 10);

    // seed 1, three vectors, zero response.
    exp_vec0_q.push_back(21'h1);
    exp_vec0_q.push_back(21'h2);
    exp_vec0_q.push_back(21'h4);
    exp_done0_q.push_back(done_t'{sig: 29'h0, cnt: 16'd3, cyc: 4});
    resp0 = 29'h0;
    start_run0(21'h1, 16'd3);
    wait_done(0, 20);
    check("vec_hold_after_run", 64'(vec0), 64'(21'h4));

    // resp=1 for two vectors: 0 -> 1 -> 3.
    exp_vec0_q.push_back(21'h1);
    exp_vec0_q.push_back(21'h2);
    exp_done0_q.push_back(done_t'{sig: 29'h3, cnt: 16'd2, cyc: 3});
    resp0 = 29'h1;
    start_run0(21'h1, 16'd2);
    wait_done(0, 20);

    // Zero seed becomes all-ones; start held through RUN and DONE is ignored.
    exp_vec0_q.push_back(21'h1FFFFF);
    exp_vec0_q.push_back(21'h1FFFFE);
    exp_done0_q.push_back(done_t'{sig: 29'h3, cnt: 16'd2, cyc: 3});
    start_run0(21'h0, 16'd2);
    start0 = 1'b1;
    wait_done(0, 20);
    @(negedge clk);
    start0 = 1'b0;
    repeat (3) @(negedge clk);
    check("no_restart_busy", 64'(busy0), 64'(0));

    // Abort in the second RUN cycle: no done, signature frozen, then a clean run.
    exp_vec0_q.push_back(21'h3);
    exp_vec0_q.push_back(21'h6);
    start_run0(21'h3, 16'd5);
    @(negedge clk);
    @(negedge clk);
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    check("abort_busy", 64'(busy0), 64'(0));
    repeat (4) @(negedge clk);
    check("abort_sig_frozen", 64'(sig0), 64'(29'h3));
    exp_vec0_q.push_back(21'h1);
    exp_vec0_q.push_back(21'h2);
    exp_vec0_q.push_back(21'h4);
    exp_done0_q.push_back(done_t'{sig: 29'h0, cnt: 16'd3, cyc: 4});
    resp0 = 29'h0;
    start_run0(21'h1, 16'd3);
    wait_done(0, 20);

`ifdef CCG_EQUIV_CHECK_EN
    check("mismatch_clear", 64'(mm0), 64'(0));
    for (int i = 0; i < 8; i++) exp_vec0_q.push_back(21'h1 << i);
    exp_done0_q.push_back(done_t'{sig: 29'h0, cnt: 16'd8, cyc: 9});
    equiv_mode = 1'b1;
    start_run0(21'h1, 16'd8);
    wait_done(0, 30);
    equiv_mode = 1'b0;
    check("mismatch", 64'(mm0), 64'(1));
    check("mismatch_idx", 64'(mmidx0), 64'(5));
`endif

    // LAT=2: responses folded in cycles 3..5 only -> 1, 2, 4.
    exp_done1_q.push_back(done_t'{sig: 29'h4, cnt: 16'd3, cyc: 6});
    win1 = 1'b1;
    start_run1(21'h1, 3'd3);
    wait_done(1, 20);
    win1 = 1'b0;

    // Maximum count for a 3-bit counter: 7 vectors, done at 7+2+1.
    exp_done1_q.push_back(done_t'{sig: 29'h0, cnt: 16'd7, cyc: 10});
    start_run1(21'h5, 3'd7);
    wait_done(1, 30);

    repeat (4) @(negedge clk);
    check("vec0_queue_drained", 64'(exp_vec0_q.size()), 64'(0));
    check("done0_queue_drained", 64'(exp_done0_q.size()), 64'(0));
    check("done1_queue_drained", 64'(exp_done1_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
